cycle_sequencer: RTL

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

---
 rtl/cycle_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction phase sequencer (IF/ID/EX/MEM/WB) with retired-instruction counter.
// Optional MEM_WAIT_EN adds a mem_ready port that stalls IF and MEM until memory responds.

`ifndef OPCODE
`define OPCODE 6
`endif
`ifndef STATE_LEN
`define STATE_LEN 3
`endif
`ifndef OP_R_TYPE
`define OP_R_TYPE 6'b000000
`endif
`ifndef OP_J
`define OP_J 6'b000010
`endif
`ifndef OP_BEQ
`define OP_BEQ 6'b000100
`endif
`ifndef OP_ADDI
`define OP_ADDI 6'b001000
`endif
`ifndef OP_ORI
`define OP_ORI 6'b001101
`endif
`ifndef OP_LW
`define OP_LW 6'b100011
`endif
`ifndef OP_SW
`define OP_SW 6'b101011
`endif

// state | meaning
// IF    | fetch: load IR, read memory, PC+4
// ID    | decode: latch opcode, retire j, flag illegal opcodes
// EX    | execute: resolve beq, route ALU ops to WB and loads/stores to MEM
// MEM   | data access: lw reads, sw writes and retires
// WB    | register write-back and retire
module cycle_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`OPCODE-1:0]    opcode,
    input  logic                  zero,
`ifdef MEM_WAIT_EN
    input  logic                  mem_ready,
`endif
    output logic [`STATE_LEN-1:0] state,
    output logic                  ir_write_en,
    output logic                  pc_write_en,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic                  reg_write_en,
    output logic                  instr_done,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      instr_cnt
);

    typedef enum logic [`STATE_LEN-1:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t             cur;
    state_t             nxt;
    logic [`OPCODE-1:0] op_q;
    logic               mem_go;

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    assign state = cur;

    always_comb begin
        nxt          = S_IF;
        ir_write_en  = 1'b0;
        pc_write_en  = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        reg_write_en = 1'b0;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        case (cur)
            S_IF: begin
                // IR load and read stay asserted through a stall; PC advances only once
                ir_write_en = 1'b1;
                mem_read_en = 1'b1;
                pc_write_en = mem_go;
                nxt         = mem_go ? S_ID : S_IF;
            end
            S_ID: begin
                case (opcode)
                    `OP_J: begin
                        pc_write_en = 1'b1;
                        instr_done  = 1'b1;
                        nxt         = S_IF;
                    end
                    `OP_R_TYPE, `OP_ADDI, `OP_ORI, `OP_BEQ, `OP_LW, `OP_SW:
                        nxt = S_EX;
                    default: begin
                        illegal_op = 1'b1;
                        nxt        = S_IF;
                    end
                endcase
            end
            S_EX: begin
                case (op_q)
                    `OP_BEQ: begin
                        pc_write_en = zero;
                        instr_done  = 1'b1;
                        nxt         = S_IF;
                    end
                    `OP_LW, `OP_SW: nxt = S_MEM;
                    default:        nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (op_q == `OP_SW) begin
                    mem_write_en = 1'b1;
                    instr_done   = mem_go;
                    nxt          = mem_go ? S_IF : S_MEM;
                end else begin
                    mem_read_en = 1'b1;
                    nxt         = mem_go ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                reg_write_en = 1'b1;
                instr_done   = 1'b1;
                nxt          = S_IF;
            end
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_IF;
            op_q      <= '0;
            instr_cnt <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_ID)
                op_q <= opcode;
            if (instr_done)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule
